// File: rtl/hh_spike_event_streamer.sv
// hh_spike_event_streamer
// Timestamps rising edges of the two neuron spike flags, queues them as
// 16-bit event words ({neuron_id, timestamp[14:0]}) in a small FIFO, and
// streams each word out as two bytes (high byte first) over a valid/ready
// byte interface.
module hh_spike_event_streamer #(
   parameter int FIFO_DEPTH = 8,   // power of two, >= 2
   parameter int PRESCALE   = 1    // enabled cycles per timestamp tick, >= 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          ena,
   input  logic                          spike1_i,
   input  logic                          spike2_i,
   input  logic                          clear_i,
   output logic [7:0]                    out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
   localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SEND_HI = 2'd1,
      SEND_LO = 2'd2
   } state_t;

   // Timestamp and history state
   logic [14:0]    r_ts;
   logic [PW-1:0]  r_ps;
   logic           r_spike1_q;
   logic           r_spike2_q;

   // Event FIFO state
   logic [15:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0]  r_wptr;
   logic [AW-1:0]  r_rptr;
   logic [LW-1:0]  r_level;
   logic           r_overflow;

   // Output side state
   state_t         r_state;
   logic [15:0]    r_word;
   logic [7:0]     r_out_data;
   logic           r_out_valid;

   // Combinational signals
   logic           w_edge1;
   logic           w_edge2;
   logic [LW-1:0]  w_free;
   logic           w_wr1;
   logic           w_wr2;
   logic           w_drop;
   logic [AW-1:0]  w_waddr2;
   logic [LW-1:0]  w_nwr;
   logic           w_nonempty;
   logic [15:0]    w_head;
   logic           w_pop;
   state_t         w_state_nxt;
   logic [15:0]    w_word_nxt;
   logic [7:0]     w_data_nxt;
   logic           w_valid_nxt;

   // Prescaled 15-bit timestamp; frozen while ena is low, zeroed by clear
   // NOTE: clocked state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ts <= '0;
         r_ps <= '0;
      end else if (clear_i) begin
         r_ts <= '0;
         r_ps <= '0;
      end else if (ena) begin
         if (r_ps == PS_LAST) begin
            r_ps <= '0;
            r_ts <= r_ts + 15'd1;
         end else begin
            r_ps <= r_ps + PW'(1);
         end
      end
   end

   // Spike history follows the inputs every cycle, independent of ena
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_spike1_q <= 1'b0;
         r_spike2_q <= 1'b0;
      end else begin
         r_spike1_q <= spike1_i;
         r_spike2_q <= spike2_i;
      end
   end

   // Edge detection and admission: space comes from the start-of-cycle
   // level only, N1 takes the first free slot, N2 is dropped first
   assign w_edge1  = ena & ~clear_i & spike1_i & ~r_spike1_q;
   assign w_edge2  = ena & ~clear_i & spike2_i & ~r_spike2_q;
   assign w_free   = DEPTH_L - r_level;
   assign w_wr1    = w_edge1 & (w_free != '0);
   assign w_wr2    = w_edge2 & (w_edge1 ? (w_free >= LW'(2)) : (w_free != '0));
   assign w_drop   = (w_edge1 & ~w_wr1) | (w_edge2 & ~w_wr2);
   assign w_waddr2 = w_wr1 ? (r_wptr + AW'(1)) : r_wptr;
   assign w_nwr    = LW'(w_wr1) + LW'(w_wr2);

   assign w_nonempty = (r_level != '0);
   assign w_head     = r_mem[r_rptr];

   // Event storage
   // NOTE: the data array has no reset; pointers and level define validity.
   always_ff @(posedge clk) begin
      if (w_wr1) r_mem[r_wptr]   <= {1'b0, r_ts};
      if (w_wr2) r_mem[w_waddr2] <= {1'b1, r_ts};
   end

   // FIFO pointers, level and sticky overflow flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_level    <= '0;
         r_overflow <= 1'b0;
      end else if (clear_i) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_level    <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_wptr  <= r_wptr + AW'(w_wr1) + AW'(w_wr2);
         r_rptr  <= r_rptr + AW'(w_pop);
         r_level <= r_level + w_nwr - LW'(w_pop);
         if (w_drop) r_overflow <= 1'b1;
      end
   end

   // Output FSM state and registered byte interface
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_word      <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_word      <= w_word_nxt;
         r_out_data  <= w_data_nxt;
         r_out_valid <= w_valid_nxt;
      end
   end

   // Output FSM next state: pop into the holding word, send high then low
   // byte, and chain directly into the next entry when one is waiting
   // NOTE: every output gets a default first so no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_word_nxt  = r_word;
      w_data_nxt  = r_out_data;
      w_valid_nxt = r_out_valid;
      w_pop       = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_nonempty) begin
               w_pop       = 1'b1;
               w_word_nxt  = w_head;
               w_data_nxt  = w_head[15:8];
               w_valid_nxt = 1'b1;
               w_state_nxt = SEND_HI;
            end
         end
         SEND_HI: begin
            if (r_out_valid && out_ready) begin
               w_data_nxt  = r_word[7:0];
               w_state_nxt = SEND_LO;
            end
         end
         SEND_LO: begin
            if (r_out_valid && out_ready) begin
               if (w_nonempty) begin
                  w_pop       = 1'b1;
                  w_word_nxt  = w_head;
                  w_data_nxt  = w_head[15:8];
                  w_state_nxt = SEND_HI;
               end else begin
                  w_valid_nxt = 1'b0;
                  w_state_nxt = IDLE;
               end
            end
         end
         default: begin
            w_valid_nxt = 1'b0;
            w_state_nxt = IDLE;
         end
      endcase
      if (clear_i) begin
         w_pop       = 1'b0;
         w_data_nxt  = '0;
         w_valid_nxt = 1'b0;
         w_state_nxt = IDLE;
      end
   end

   assign out_data   = r_out_data;
   assign out_valid  = r_out_valid;
   assign overflow   = r_overflow;
   assign fifo_level = r_level;

endmodule

// File: tb/tb_hh_spike_event_streamer.sv
// Directed bench for hh_spike_event_streamer: single events, simultaneous
// edges, FIFO saturation and overflow, timestamp wrap, prescaling, enable
// gating, synchronous clear and asynchronous reset.
module tb_hh_spike_event_streamer;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic       spike1;
   logic       spike2;
   logic       p_spike1;
   logic       p_spike2;
   logic       clear;
   logic       out_ready;

   logic [7:0] out_data;
   logic       out_valid;
   logic       overflow;
   logic [3:0] fifo_level;

   logic [7:0] p_out_data;
   logic       p_out_valid;
   logic       p_overflow;
   logic [3:0] p_fifo_level;

   int n_tests = 0;
   int n_fail  = 0;

   hh_spike_event_streamer #(.FIFO_DEPTH(8), .PRESCALE(1)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .spike1_i   (spike1),
      .spike2_i   (spike2),
      .clear_i    (clear),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .overflow   (overflow),
      .fifo_level (fifo_level)
   );

   hh_spike_event_streamer #(.FIFO_DEPTH(8), .PRESCALE(4)) u_dut_ps (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .spike1_i   (p_spike1),
      .spike2_i   (p_spike2),
      .clear_i    (clear),
      .out_data   (p_out_data),
      .out_valid  (p_out_valid),
      .out_ready  (out_ready),
      .overflow   (p_overflow),
      .fifo_level (p_fifo_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
         $error("%s observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; ena = 1'b0; spike1 = 1'b0; spike2 = 1'b0;
      p_spike1 = 1'b0; p_spike2 = 1'b0; clear = 1'b0; out_ready = 1'b0;

      // Reset state
      #1;
      check("rst_valid",    out_valid,  0);
      check("rst_data",     out_data,   0);
      check("rst_level",    fifo_level, 0);
      check("rst_overflow", overflow,   0);
      check("rst_ps_level", p_fifo_level, 0);
      repeat (3) tick();
      rst_n = 1'b1;

      // Single event at ts=0x0010, flag held three cycles
      out_ready = 1'b1;
      ena = 1'b1;
      repeat (16) tick();
      spike1 = 1'b1;
      tick();
      check("t1_level_after_write", fifo_level, 1);
      check("t1_valid_after_write", out_valid, 0);
      tick();
      check("t1_hi_valid", out_valid, 1);
      check("t1_hi_data",  out_data, 8'h00);
      check("t1_level_popped", fifo_level, 0);
      tick();
      spike1 = 1'b0;
      check("t1_lo_valid", out_valid, 1);
      check("t1_lo_data",  out_data, 8'h10);
      tick();
      check("t1_idle_valid", out_valid, 0);
      tick();
      check("t1_no_repeat_valid", out_valid, 0);
      check("t1_no_repeat_level", fifo_level, 0);

      // Simultaneous edges at ts=0x0123
      do_clear();
      check("t2_overflow", overflow, 0);
      repeat (291) tick();
      spike1 = 1'b1; spike2 = 1'b1;
      tick();
      spike1 = 1'b0; spike2 = 1'b0;
      check("t2_level_both", fifo_level, 2);
      tick();
      check("t2_b0", out_data, 8'h01);
      check("t2_b0_valid", out_valid, 1);
      check("t2_level_after_pop", fifo_level, 1);
      tick();
      check("t2_b1", out_data, 8'h23);
      tick();
      check("t2_b2", out_data, 8'h81);
      check("t2_b2_valid", out_valid, 1);
      check("t2_level_empty", fifo_level, 0);
      tick();
      check("t2_b3", out_data, 8'h23);
      tick();
      check("t2_idle", out_valid, 0);

      // Saturation: ten spikes with out_ready low, starting at ts=0x0100
      do_clear();
      out_ready = 1'b0;
      repeat (256) tick();
      for (int i = 0; i < 10; i++) begin
         spike1 = 1'b1;
         tick();
         spike1 = 1'b0;
         tick();
         check("t3_fill_level", fifo_level, (i < 8) ? i : 8);
         check("t3_fill_valid", out_valid, 1);
         check("t3_fill_hold",  out_data, 8'h01);
         check("t3_fill_ovf",   overflow, (i == 9) ? 1 : 0);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         check("t3_drain_hi_valid", out_valid, 1);
         check("t3_drain_hi", out_data, 8'h01);
         tick();
         check("t3_drain_lo", out_data, 2 * i);
         tick();
      end
      check("t3_drained_valid", out_valid, 0);
      check("t3_drained_level", fifo_level, 0);
      check("t3_ovf_sticky", overflow, 1);

      // Timestamp wrap: events at 0x7FFF and 0x0001
      do_clear();
      check("t4_ovf_cleared", overflow, 0);
      repeat (32767) tick();
      spike1 = 1'b1;
      tick();
      spike1 = 1'b0;
      check("t4_valid_write", out_valid, 0);
      tick();
      spike1 = 1'b1;
      check("t4_b0", out_data, 8'h7F);
      tick();
      spike1 = 1'b0;
      check("t4_b1", out_data, 8'hFF);
      tick();
      check("t4_b2", out_data, 8'h00);
      check("t4_b2_valid", out_valid, 1);
      tick();
      check("t4_b3", out_data, 8'h01);
      tick();
      check("t4_idle", out_valid, 0);

      // PRESCALE=4 instance: events at ts 2, 3 and 4
      do_clear();
      out_ready = 1'b0;
      repeat (11) tick();
      p_spike1 = 1'b1;
      tick();
      p_spike1 = 1'b0;
      repeat (3) tick();
      p_spike1 = 1'b1;
      tick();
      p_spike1 = 1'b0;
      tick();
      p_spike1 = 1'b1;
      tick();
      p_spike1 = 1'b0;
      check("t5_ps_level", p_fifo_level, 2);
      check("t5_ps_valid", p_out_valid, 1);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("t5_ps_hi", p_out_data, 8'h00);
         tick();
         check("t5_ps_lo", p_out_data, i + 2);
         tick();
      end
      check("t5_ps_idle", p_out_valid, 0);

      // Enable gating: drain while frozen, no event for a flag held across ena rise
      do_clear();
      repeat (5) tick();
      spike1 = 1'b1;
      tick();
      ena = 1'b0;
      spike1 = 1'b0;
      tick();
      check("t6_drain_hi_valid", out_valid, 1);
      check("t6_drain_hi", out_data, 8'h00);
      tick();
      check("t6_drain_lo", out_data, 8'h05);
      tick();
      check("t6_drain_idle", out_valid, 0);
      spike1 = 1'b1;
      repeat (17) tick();
      check("t6_frozen_level", fifo_level, 0);
      ena = 1'b1;
      tick();
      tick();
      check("t6_held_level", fifo_level, 0);
      check("t6_held_valid", out_valid, 0);
      spike1 = 1'b0;
      tick();
      spike1 = 1'b1;
      tick();
      spike1 = 1'b0;
      tick();
      check("t6_ts_hi", out_data, 8'h00);
      check("t6_ts_valid", out_valid, 1);
      tick();
      check("t6_ts_lo", out_data, 8'h09);
      tick();
      check("t6_ts_idle", out_valid, 0);

      // clear_i in SEND_HI with three entries queued; edge in clear cycle discarded
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         spike1 = 1'b1;
         tick();
         spike1 = 1'b0;
         tick();
      end
      check("t7_queued_level", fifo_level, 3);
      check("t7_queued_valid", out_valid, 1);
      clear = 1'b1;
      spike2 = 1'b1;
      tick();
      clear = 1'b0;
      check("t7_clr_valid", out_valid, 0);
      check("t7_clr_level", fifo_level, 0);
      check("t7_clr_ovf",   overflow, 0);
      spike1 = 1'b1;
      out_ready = 1'b1;
      tick();
      spike1 = 1'b0; spike2 = 1'b0;
      check("t7_post_level", fifo_level, 1);
      tick();
      check("t7_post_hi", out_data, 8'h00);
      check("t7_post_hi_valid", out_valid, 1);
      tick();
      check("t7_post_lo", out_data, 8'h00);
      tick();
      check("t7_post_idle", out_valid, 0);

      // Asynchronous reset with clear_i dropping during the reset pulse
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         spike1 = 1'b1;
         tick();
         spike1 = 1'b0;
         tick();
      end
      check("t8_pre_ovf",   overflow, 1);
      check("t8_pre_level", fifo_level, 8);
      clear = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      check("t8_rst_valid", out_valid, 0);
      check("t8_rst_level", fifo_level, 0);
      check("t8_rst_ovf",   overflow, 0);
      check("t8_rst_data",  out_data, 0);
      tick();
      clear = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      check("t8_rel_valid", out_valid, 0);
      check("t8_rel_level", fifo_level, 0);
      out_ready = 1'b1;
      spike1 = 1'b1;
      tick();
      spike1 = 1'b0;
      check("t8_ev_level", fifo_level, 1);
      tick();
      check("t8_ev_hi", out_data, 8'h00);
      check("t8_ev_valid", out_valid, 1);
      tick();
      check("t8_ev_lo", out_data, 8'h00);
      tick();
      check("t8_ev_idle", out_valid, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hh_spike_event_streamer.md
Name: hh_spike_event_streamer

Overview:
- Readout-side counterpart to the HH/STDP neuron core.
- Consumes the two neuron spike flags, timestamps each rising edge, and buffers events in a small FIFO.
- Streams each event out as two bytes over a valid/ready byte interface, so off-chip logic can rebuild spike trains without sampling every cycle.
- Sits between the neuron core outputs and the pin mux.

Parameters:
FIFO_DEPTH, 8, event FIFO entries; power of two, minimum 2
PRESCALE, 1, enabled clock cycles per timestamp tick; minimum 1

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  block enable; low freezes capture and the timestamp
spike1_i  input  1  neuron 1 spike flag (level, may stay high several cycles)
spike2_i  input  1  neuron 2 spike flag
clear_i  input  1  synchronous flush
out_data  output  8  streamed byte
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts byte
overflow  output  1  sticky: at least one event dropped
fifo_level  output  $clog2(FIFO_DEPTH)+1  entries currently stored

Behaviour:
- Reset is asynchronous and active-low on rst_n; one clock, clk.
- Reset values: out_data=0, out_valid=0, overflow=0, fifo_level=0, timestamp=0, spike history regs=0, FSM=IDLE.
- Event word is 16 bits: [15]=neuron id (0=N1, 1=N2), [14:0]=timestamp.
- Timestamp is a 15-bit counter with a prescale counter. It advances only when ena=1, by 1 every PRESCALE enabled cycles, and wraps 0x7FFF->0x0000.
- An event takes the timestamp value held at the start of its detection cycle.
- Edge detect: edge_n = spike_n_i & ~spike_n_q. Events are generated only when ena=1.
- spike_n_q updates every cycle regardless of ena, so a flag still high when ena rises produces no event.
- Write on the posedge that samples the edge.
- Both edges in the same cycle: N1 entry is written first, then N2 in the next slot.
- Free space is judged from fifo_level at the start of the cycle. A same-cycle pop does not free a slot.
- Excess events are dropped: N2 before N1. Any drop sets overflow, which stays high until clear_i or reset.
- Output FSM states: IDLE, SEND_HI, SEND_LO.
  - IDLE: if FIFO is non-empty, pop the head into the output holding register, go to SEND_HI, set out_data = word[15:8] and out_valid=1 (registered).
  - SEND_HI: on out_valid & out_ready, go to SEND_LO with out_data = word[7:0].
  - SEND_LO: on handshake, if FIFO is non-empty, pop the next entry and go straight to SEND_HI with no idle cycle; otherwise go to IDLE with out_valid=0.
- Handshake rules: out_data is stable while out_valid=1 and out_ready=0. out_valid never drops without a handshake, except on clear_i or reset.
- Latency: an event written at edge k has out_valid=1 with its high byte after edge k+1 (FIFO empty, FSM in IDLE). Minimum 2 cycles per event.
- fifo_level counts stored entries only; the entry held in the output register is not counted. Range 0..FIFO_DEPTH; the level is FIFO_DEPTH when full.
- clear_i has priority over everything and takes effect at the next edge: FIFO emptied, FSM=IDLE, out_valid=0, timestamp and prescaler=0, overflow=0. Edges in the clear cycle are discarded.
- ena=0 does not stall the output FSM; buffered events continue to drain.

Test Plan:
- Reset, ena=1, PRESCALE=1; spike1_i high for 3 cycles starting when timestamp=0x0010 -> exactly one event; out_valid rises 2 edges later; bytes 0x00 then 0x10; fifo_level returns to 0.
- spike1_i and spike2_i rise together at timestamp 0x0123, out_ready=1 -> byte stream 0x01,0x23,0x81,0x23 with back-to-back handshakes and no idle gap.
- out_ready=0 and 10 single-neuron spikes, FIFO_DEPTH=8 -> fifo_level saturates at 8; 9th spike held in the output register; 10th dropped; overflow=1; out_data holds its value; release out_ready -> 9 events in order.
- Run timestamp to 0x7FFF, spike at 0x7FFF and again 2 cycles later -> words 0x7FFF then 0x0001; PRESCALE=4 -> timestamp advances once per 4 enabled cycles.
- spike1_i held high while ena toggles 0->1 -> no event; ena=0 for 20 cycles -> timestamp frozen while buffered events still drain.
- clear_i asserted mid-SEND_HI with 3 entries queued, and asserted low again during a long rst_n pulse -> out_valid=0, fifo_level=0, overflow=0, timestamp=0 on the next edge / immediately on reset.
